multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle sequencer for the MIPS-subset datapath: replaces the single-cycle opcode decoder with a Moore state machine that time-shares one ALU and one unified instruction/data memory across fetch, decode, execute, memory and write-back steps. Sits beside the register file and ALU control, driving all datapath mux selects and write strobes from the latched opcode. Stalls on a memory ready handshake so slow memories are tolerated.

## Interface
- No parameters.
- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  synchronous, active-high reset
- opcode_i  in  6  opcode field of the instruction register (valid from DECODE on)
- mem_ready_i  in  1  memory completes current read/write this cycle
- pcWrite_o  out  1  unconditional PC load
- pcWriteCond_o  out  1  PC load qualified by ALU zero (beq)
- iorD_o  out  1  memory address select: 0 = PC, 1 = ALUOut
- memRead_o / memWrite_o  out  1 each  memory strobes, held until mem_ready_i
- irWrite_o  out  1  load instruction register
- regDst_o  out  1  write register: 0 = rt, 1 = rd
- memToReg_o  out  1  write-back data: 0 = ALUOut, 1 = MDR
- regWrite_o  out  1  register file write enable
- aluSrcA_o  out  1  0 = PC, 1 = register A
- aluSrcB_o  out  2  0 = B, 1 = constant 4, 2 = sign-ext imm, 3 = sign-ext imm << 2
- aluOp_o  out  4  ALU control class (same encoding as the single-cycle decoder)
- pcSource_o  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target
- instrDone_o  out  1  one-cycle pulse in the final state of each instruction
- illegal_o  out  1  one-cycle pulse when DECODE sees an unsupported opcode
- state_o  out  4  current state encoding, for debug/verification

## Operation
- States (encoding): FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, R_EXEC 6, R_WB 7, BRANCH 8, I_EXEC 9, I_WB 10, JUMP 11. Codes 12-15 unreachable; if entered, next state FETCH, all outputs 0.
- FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=1, aluOp=0000, pcSource=0. irWrite and pcWrite asserted only in the cycle mem_ready_i=1; then -> DECODE, else stay.
- DECODE: aluSrcA=0, aluSrcB=3, aluOp=0000 (branch target precompute). Next by opcode: 000000 -> R_EXEC; 100011/101011 -> MEM_ADDR; 000100 -> BRANCH; 001000/001100/001101/001010/001110 -> I_EXEC; 000010 -> JUMP (if JUMP_EN); else -> FETCH with illegal_o=1.
- MEM_ADDR: aluSrcA=1, aluSrcB=2, aluOp=0000; lw -> MEM_READ, sw -> MEM_WRITE.
- MEM_READ: memRead=1, iorD=1; -> MEM_WB on mem_ready_i.
- MEM_WB: regDst=0, memToReg=1, regWrite=1, instrDone=1; -> FETCH.
- MEM_WRITE: memWrite=1, iorD=1; on mem_ready_i instrDone=1, -> FETCH.
- R_EXEC: aluSrcA=1, aluSrcB=0, aluOp=0010; -> R_WB. R_WB: regDst=1, memToReg=0, regWrite=1, instrDone=1; -> FETCH.
- I_EXEC: aluSrcA=1, aluSrcB=2, aluOp per opcode: addi 0011, andi 0100, ori 0101, slti 0110, xori 0111; -> I_WB. I_WB: regDst=0, memToReg=0, regWrite=1, instrDone=1, aluOp held; -> FETCH.
- BRANCH: aluSrcA=1, aluSrcB=0, aluOp=0001, pcWriteCond=1, pcSource=1, instrDone=1; -> FETCH.
- JUMP: pcWrite=1, pcSource=2, instrDone=1; -> FETCH.
- All outputs not listed for a state are 0. Outputs are pure functions of state, opcode_i and mem_ready_i; opcode_i is sampled only from DECODE onward (IR is stable then).

## Timing
- rst_i high at a rising edge: state <- FETCH. While rst_i is high, every strobe (pcWrite, pcWriteCond, memRead, memWrite, irWrite, regWrite, instrDone, illegal) is forced 0; selects 0; state_o reads 0 after the first reset edge.
- Reset mid-instruction aborts it; no write strobe appears in the reset cycle.
- Cycles per instruction with mem_ready_i tied 1: R-type 4, I-type 4, lw 5, sw 4, beq 3, j 3, illegal 2. Each low cycle of mem_ready_i in FETCH/MEM_READ/MEM_WRITE adds one cycle.
- memRead/memWrite and iorD held constant across stall cycles; single-cycle strobes (irWrite, pcWrite) never assert during a stall.

## Configuration
- MULTICYCLE_CTRL_JUMP_EN defined: opcode 000010 decodes to DECODE -> JUMP -> FETCH, 3 cycles.
- Undefined: JUMP state unreachable; opcode 000010 treated as illegal (illegal_o pulse, -> FETCH).

## Test plan
- Reset: rst_i=1 two cycles from state 6 -> state_o=0, all strobes 0; release -> memRead_o=1 in FETCH.
- addi (001000), ready=1 -> states 0,1,9,10; aluOp_o=0011 in 9 and 10; regWrite_o=1 only in 10; instrDone_o one pulse; 4 cycles.
- lw (100011) with mem_ready_i low 2 cycles in MEM_READ -> states 0,1,2,3,3,3,4; memRead_o/iorD_o=1 throughout state 3; memToReg_o=1 in 4; 7 cycles.
- beq (000100) -> states 0,1,8; pcWriteCond_o=1, aluOp_o=0001, pcSource_o=1 in 8; regWrite_o never 1.
- Opcode 111111 -> states 0,1,0; illegal_o pulse in DECODE; no write strobe; with macro off, 000010 behaves identically; with macro on, 000010 -> states 0,1,11 with pcSource_o=2.
- FETCH stall 3 cycles then rst_i mid-R_EXEC -> irWrite_o/pcWrite_o only on ready cycle; reset cycle shows regWrite_o=0, next state FETCH.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset sequencer: Moore FSM driving datapath selects and strobes.
// Optional jump support is enabled by defining MULTICYCLE_CTRL_JUMP_EN.
module multicycle_ctrl (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] opcode_i,
  input  logic       mem_ready_i,
  output logic       pcWrite_o,
  output logic       pcWriteCond_o,
  output logic       iorD_o,
  output logic       memRead_o,
  output logic       memWrite_o,
  output logic       irWrite_o,
  output logic       regDst_o,
  output logic       memToReg_o,
  output logic       regWrite_o,
  output logic       aluSrcA_o,
  output logic [1:0] aluSrcB_o,
  output logic [3:0] aluOp_o,
  output logic [1:0] pcSource_o,
  output logic       instrDone_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_I_EXEC    = 4'd9,
    S_I_WB      = 4'd10,
    S_JUMP      = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_XORI = 6'b001110;
`ifdef MULTICYCLE_CTRL_JUMP_EN
  localparam logic [5:0] OP_J    = 6'b000010;
`endif

  localparam ctrl_t CTRL_IDLE = {$bits(ctrl_t){1'b0}};

  // ALU class for immediate arithmetic, held across I_EXEC and I_WB
  function automatic logic [3:0] imm_alu_op(input logic [5:0] op);
    logic [3:0] aop;
    case (op)
      OP_ADDI: aop = 4'b0011;
      OP_ANDI: aop = 4'b0100;
      OP_ORI:  aop = 4'b0101;
      OP_SLTI: aop = 4'b0110;
      OP_XORI: aop = 4'b0111;
      default: aop = 4'b0000;
    endcase
    return aop;
  endfunction

  state_t state_r;
  state_t next_state_s;
  ctrl_t  ctrl_s;
  ctrl_t  ctrl_out_s;

  // State register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and per-state control decode
  always_comb begin
    ctrl_s       = CTRL_IDLE;
    next_state_s = S_FETCH;
    case (state_r)
      S_FETCH: begin
        ctrl_s.mem_read  = 1'b1;
        ctrl_s.alu_src_b = 2'd1;
        // PC+4 and IR load only in the cycle the memory delivers
        if (mem_ready_i) begin
          ctrl_s.ir_write = 1'b1;
          ctrl_s.pc_write = 1'b1;
          next_state_s    = S_DECODE;
        end else begin
          next_state_s    = S_FETCH;
        end
      end
      S_DECODE: begin
        ctrl_s.alu_src_b = 2'd3;
        case (opcode_i)
          OP_R:          next_state_s = S_R_EXEC;
          OP_LW, OP_SW:  next_state_s = S_MEM_ADDR;
          OP_BEQ:        next_state_s = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_XORI:
                         next_state_s = S_I_EXEC;
`ifdef MULTICYCLE_CTRL_JUMP_EN
          OP_J:          next_state_s = S_JUMP;
`endif
          default: begin
            ctrl_s.illegal = 1'b1;
            next_state_s   = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = 2'd2;
        if (opcode_i == OP_LW) begin
          next_state_s = S_MEM_READ;
        end else if (opcode_i == OP_SW) begin
          next_state_s = S_MEM_WRITE;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_MEM_READ: begin
        ctrl_s.mem_read = 1'b1;
        ctrl_s.iord     = 1'b1;
        if (mem_ready_i) begin
          next_state_s = S_MEM_WB;
        end else begin
          next_state_s = S_MEM_READ;
        end
      end
      S_MEM_WB: begin
        ctrl_s.mem_to_reg = 1'b1;
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.instr_done = 1'b1;
        next_state_s      = S_FETCH;
      end
      S_MEM_WRITE: begin
        ctrl_s.mem_write = 1'b1;
        ctrl_s.iord      = 1'b1;
        if (mem_ready_i) begin
          ctrl_s.instr_done = 1'b1;
          next_state_s      = S_FETCH;
        end else begin
          next_state_s      = S_MEM_WRITE;
        end
      end
      S_R_EXEC: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_op    = 4'b0010;
        next_state_s     = S_R_WB;
      end
      S_R_WB: begin
        ctrl_s.reg_dst    = 1'b1;
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.instr_done = 1'b1;
        next_state_s      = S_FETCH;
      end
      S_BRANCH: begin
        ctrl_s.alu_src_a     = 1'b1;
        ctrl_s.alu_op        = 4'b0001;
        ctrl_s.pc_write_cond = 1'b1;
        ctrl_s.pc_source     = 2'd1;
        ctrl_s.instr_done    = 1'b1;
        next_state_s         = S_FETCH;
      end
      S_I_EXEC: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = 2'd2;
        ctrl_s.alu_op    = imm_alu_op(opcode_i);
        next_state_s     = S_I_WB;
      end
      S_I_WB: begin
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.instr_done = 1'b1;
        ctrl_s.alu_op     = imm_alu_op(opcode_i);
        next_state_s      = S_FETCH;
      end
      S_JUMP: begin
        ctrl_s.pc_write   = 1'b1;
        ctrl_s.pc_source  = 2'd2;
        ctrl_s.instr_done = 1'b1;
        next_state_s      = S_FETCH;
      end
      default: begin
        ctrl_s       = CTRL_IDLE;
        next_state_s = S_FETCH;
      end
    endcase
  end

  // Reset cycle suppresses every strobe and select
  always_comb begin
    if (rst_i) begin
      ctrl_out_s = CTRL_IDLE;
    end else begin
      ctrl_out_s = ctrl_s;
    end
  end

  assign pcWrite_o     = ctrl_out_s.pc_write;
  assign pcWriteCond_o = ctrl_out_s.pc_write_cond;
  assign iorD_o        = ctrl_out_s.iord;
  assign memRead_o     = ctrl_out_s.mem_read;
  assign memWrite_o    = ctrl_out_s.mem_write;
  assign irWrite_o     = ctrl_out_s.ir_write;
  assign regDst_o      = ctrl_out_s.reg_dst;
  assign memToReg_o    = ctrl_out_s.mem_to_reg;
  assign regWrite_o    = ctrl_out_s.reg_write;
  assign aluSrcA_o     = ctrl_out_s.alu_src_a;
  assign aluSrcB_o     = ctrl_out_s.alu_src_b;
  assign aluOp_o       = ctrl_out_s.alu_op;
  assign pcSource_o    = ctrl_out_s.pc_source;
  assign instrDone_o   = ctrl_out_s.instr_done;
  assign illegal_o     = ctrl_out_s.illegal;
  assign state_o       = state_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Table-driven bench for multicycle_ctrl: per-cycle state and control vectors,
// plus cycle-count sequences. Jump rows follow MULTICYCLE_CTRL_JUMP_EN.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
  logic       regDst, memToReg, regWrite, aluSrcA, instrDone, illegal;
  logic [1:0] aluSrcB, pcSource;
  logic [3:0] aluOp, state;
  logic [19:0] act;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .mem_ready_i(mem_ready),
    .pcWrite_o(pcWrite), .pcWriteCond_o(pcWriteCond), .iorD_o(iorD),
    .memRead_o(memRead), .memWrite_o(memWrite), .irWrite_o(irWrite),
    .regDst_o(regDst), .memToReg_o(memToReg), .regWrite_o(regWrite),
    .aluSrcA_o(aluSrcA), .aluSrcB_o(aluSrcB), .aluOp_o(aluOp),
    .pcSource_o(pcSource), .instrDone_o(instrDone), .illegal_o(illegal),
    .state_o(state)
  );

  assign act = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, regDst,
                memToReg, regWrite, aluSrcA, aluSrcB, aluOp, pcSource, instrDone, illegal};

  typedef struct {
    string       name;
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [19:0] mk(input logic pcw, pcwc, iord, mr, mw, irw, rd, mtr, rw, asa,
                                     input logic [1:0] asb, input logic [3:0] aop,
                                     input logic [1:0] pcs, input logic done, ill);
    return {pcw, pcwc, iord, mr, mw, irw, rd, mtr, rw, asa, asb, aop, pcs, done, ill};
  endfunction

  function automatic logic [19:0] e_fetch(input logic rdy);
    return mk(rdy, 1'b0, 1'b0, 1'b1, 1'b0, rdy, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 4'd0, 2'd0, 1'b0, 1'b0);
  endfunction

  function automatic logic [19:0] e_dec(input logic ill);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 4'd0, 2'd0, 1'b0, ill);
  endfunction

  task automatic add(input string nm, input logic r, input logic [5:0] op, input logic rdy,
                     input logic [3:0] st, input logic [19:0] e);
    vec_t v;
    v.name = nm; v.rst = r; v.op = op; v.rdy = rdy; v.st = st; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic seq_itype(input string nm, input logic [5:0] op, input logic [3:0] aop);
    add(nm, 1'b0, op, 1'b1, 4'd0, e_fetch(1'b1));
    add(nm, 1'b0, op, 1'b1, 4'd1, e_dec(1'b0));
    add(nm, 1'b0, op, 1'b1, 4'd9, mk(0,0,0,0,0,0,0,0,0,1, 2'd2, aop, 2'd0, 0,0));
    add(nm, 1'b0, op, 1'b1, 4'd10, mk(0,0,0,0,0,0,0,0,1,0, 2'd0, aop, 2'd0, 1,0));
  endtask

  task automatic check(input string nm, input logic [19:0] a, input logic [19:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  // Runs one instruction from FETCH with ready tied high and counts cycles to instrDone
  task automatic count_cycles(input string nm, input logic [5:0] op, input int exp_cycles);
    int cyc = 0;
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      rst = 1'b0; opcode = op; mem_ready = 1'b1;
      #1;
      cyc++;
      if (instrDone === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: instrDone not seen within 20 cycles", nm);
    end else begin
      check(nm, 20'(cyc), 20'(exp_cycles));
    end
  endtask

  initial begin
    rst = 1'b1; opcode = 6'd0; mem_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);

    add("reset_hold", 1'b1, 6'h00, 1'b1, 4'd0, 20'd0);
    seq_itype("addi", 6'b001000, 4'b0011);
    seq_itype("andi", 6'b001100, 4'b0100);
    seq_itype("ori",  6'b001101, 4'b0101);
    seq_itype("slti", 6'b001010, 4'b0110);
    seq_itype("xori", 6'b001110, 4'b0111);

    // lw with two stall cycles in MEM_READ
    add("lw", 1'b0, 6'b100011, 1'b1, 4'd0, e_fetch(1'b1));
    add("lw", 1'b0, 6'b100011, 1'b1, 4'd1, e_dec(1'b0));
    add("lw", 1'b0, 6'b100011, 1'b1, 4'd2, mk(0,0,0,0,0,0,0,0,0,1, 2'd2, 4'd0, 2'd0, 0,0));
    add("lw", 1'b0, 6'b100011, 1'b0, 4'd3, mk(0,0,1,1,0,0,0,0,0,0, 2'd0, 4'd0, 2'd0, 0,0));
    add("lw", 1'b0, 6'b100011, 1'b0, 4'd3, mk(0,0,1,1,0,0,0,0,0,0, 2'd0, 4'd0, 2'd0, 0,0));
    add("lw", 1'b0, 6'b100011, 1'b1, 4'd3, mk(0,0,1,1,0,0,0,0,0,0, 2'd0, 4'd0, 2'd0, 0,0));
    add("lw", 1'b0, 6'b100011, 1'b1, 4'd4, mk(0,0,0,0,0,0,0,1,1,0, 2'd0, 4'd0, 2'd0, 1,0));

    // sw with one stall cycle in MEM_WRITE
    add("sw", 1'b0, 6'b101011, 1'b1, 4'd0, e_fetch(1'b1));
    add("sw", 1'b0, 6'b101011, 1'b1, 4'd1, e_dec(1'b0));
    add("sw", 1'b0, 6'b101011, 1'b1, 4'd2, mk(0,0,0,0,0,0,0,0,0,1, 2'd2, 4'd0, 2'd0, 0,0));
    add("sw", 1'b0, 6'b101011, 1'b0, 4'd5, mk(0,0,1,0,1,0,0,0,0,0, 2'd0, 4'd0, 2'd0, 0,0));
    add("sw", 1'b0, 6'b101011, 1'b1, 4'd5, mk(0,0,1,0,1,0,0,0,0,0, 2'd0, 4'd0, 2'd0, 1,0));

    add("beq", 1'b0, 6'b000100, 1'b1, 4'd0, e_fetch(1'b1));
    add("beq", 1'b0, 6'b000100, 1'b1, 4'd1, e_dec(1'b0));
    add("beq", 1'b0, 6'b000100, 1'b1, 4'd8, mk(0,1,0,0,0,0,0,0,0,1, 2'd0, 4'd1, 2'd1, 1,0));

    add("rtype", 1'b0, 6'b000000, 1'b1, 4'd0, e_fetch(1'b1));
    add("rtype", 1'b0, 6'b000000, 1'b1, 4'd1, e_dec(1'b0));
    add("rtype", 1'b0, 6'b000000, 1'b1, 4'd6, mk(0,0,0,0,0,0,0,0,0,1, 2'd0, 4'd2, 2'd0, 0,0));
    add("rtype", 1'b0, 6'b000000, 1'b1, 4'd7, mk(0,0,0,0,0,0,1,0,1,0, 2'd0, 4'd0, 2'd0, 1,0));

    add("illegal", 1'b0, 6'b111111, 1'b1, 4'd0, e_fetch(1'b1));
    add("illegal", 1'b0, 6'b111111, 1'b1, 4'd1, e_dec(1'b1));

    add("jump", 1'b0, 6'b000010, 1'b1, 4'd0, e_fetch(1'b1));
`ifdef MULTICYCLE_CTRL_JUMP_EN
    add("jump", 1'b0, 6'b000010, 1'b1, 4'd1, e_dec(1'b0));
    add("jump", 1'b0, 6'b000010, 1'b1, 4'd11, mk(1,0,0,0,0,0,0,0,0,0, 2'd0, 4'd0, 2'd2, 1,0));
`else
    add("jump", 1'b0, 6'b000010, 1'b1, 4'd1, e_dec(1'b1));
`endif

    // Fetch stall, then reset aborting R_EXEC
    add("fstall", 1'b0, 6'b000000, 1'b0, 4'd0, e_fetch(1'b0));
    add("fstall", 1'b0, 6'b000000, 1'b0, 4'd0, e_fetch(1'b0));
    add("fstall", 1'b0, 6'b000000, 1'b0, 4'd0, e_fetch(1'b0));
    add("fstall", 1'b0, 6'b000000, 1'b1, 4'd0, e_fetch(1'b1));
    add("fstall", 1'b0, 6'b000000, 1'b1, 4'd1, e_dec(1'b0));
    add("rst_rexec", 1'b1, 6'b000000, 1'b1, 4'd6, 20'd0);
    add("rst_rexec", 1'b1, 6'b000000, 1'b1, 4'd0, 20'd0);
    add("rst_rexec", 1'b0, 6'b000000, 1'b0, 4'd0, e_fetch(1'b0));

    // Reset landing on MEM_WB must hide regWrite
    add("rst_memwb", 1'b0, 6'b100011, 1'b1, 4'd0, e_fetch(1'b1));
    add("rst_memwb", 1'b0, 6'b100011, 1'b1, 4'd1, e_dec(1'b0));
    add("rst_memwb", 1'b0, 6'b100011, 1'b1, 4'd2, mk(0,0,0,0,0,0,0,0,0,1, 2'd2, 4'd0, 2'd0, 0,0));
    add("rst_memwb", 1'b0, 6'b100011, 1'b1, 4'd3, mk(0,0,1,1,0,0,0,0,0,0, 2'd0, 4'd0, 2'd0, 0,0));
    add("rst_memwb", 1'b1, 6'b100011, 1'b1, 4'd4, 20'd0);
    add("rst_memwb", 1'b0, 6'b100011, 1'b0, 4'd0, e_fetch(1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; opcode = vecs[i].op; mem_ready = vecs[i].rdy;
      #1;
      check($sformatf("%s_row%0d_state", vecs[i].name, i), 20'(state), 20'(vecs[i].st));
      check($sformatf("%s_row%0d_ctrl", vecs[i].name, i), act, vecs[i].exp);
    end

    count_cycles("cpi_rtype", 6'b000000, 4);
    count_cycles("cpi_lw",    6'b100011, 5);
    count_cycles("cpi_sw",    6'b101011, 4);
    count_cycles("cpi_beq",   6'b000100, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
